resta_serial: RTL and testbench
===============================

# resta_serial

Parametrised sequential add/subtract unit that processes the operands K bits per clock cycle and reports NZCV flags. It is the successor to the combinational M-bit subtractor in the ALU datapath. It trades latency for area: one K-bit slice adder is reused over M/K cycles, with a start/done handshake toward the controlling FSM. Results and flags stay registered until the next operation completes.

## Interface
- M, default 4: operand/result width in bits; M ≥ 2.
- K, default 1: bits processed per cycle; 1 ≤ K ≤ M and M mod K = 0 (elaboration error otherwise).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only when busy = 0.
- mode  input  1  0 = subtract (A − B), 1 = add (A + B); sampled with start.
- A  input  M  first operand; sampled with start.
- B  input  M  second operand; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when R/flags have just been updated.
- R  output  M  result, registered.
- N  output  1  R[M-1].
- Z  output  1  R == 0.
- C  output  1  add: carry-out; subtract: borrow (1 when A < B unsigned).
- V  output  1  signed two's-complement overflow.

## Operation
- FSM states: IDLE, RUN.
- IDLE + start:
  - Latch A into the operand shift register a_q.
  - Latch B into b_q; B is inverted when mode = 0.
  - Set the slice carry c_q = ~mode (1 for subtract).
  - Store the operand sign bits A[M-1] and B[M-1], plus mode.
  - Clear the slice counter; go to RUN; busy = 1.
- RUN, each cycle:
  - Compute {c, s} = a_q[K-1:0] + b_q[K-1:0] + c_q.
  - Shift a_q and b_q right by K.
  - Shift s into the partial-result register from the MSB side.
  - c_q ← c; increment the counter.
- RUN, on slice M/K (final):
  - Load R with the full assembled result.
  - C = final carry for add, or inverted final carry for subtract.
  - N = R[M-1]; Z = (R == 0).
  - V, add: A[M-1] == B[M-1] and R[M-1] != A[M-1].
  - V, subtract: A[M-1] != B[M-1] and R[M-1] != A[M-1].
  - done = 1 for one cycle, busy = 0, go to IDLE.
- start while busy = 1 is ignored (no queuing); A/B/mode changes during RUN have no effect.
- R and flags change only at completion; they hold their values otherwise, including across ignored starts.
- Arithmetic is modulo 2^M; there is no saturation.

## Timing
- Reset (rst_n = 0, any time, asynchronous): state = IDLE, busy = 0, done = 0, R = 0, N = Z = C = V = 0, internal registers cleared.
- Reset mid-RUN aborts the operation; no done pulse follows, and outputs return to reset values.
- Start sampled at edge E0 → busy = 1 after E0.
- Slices are processed at edges E1 … E(M/K).
- At E(M/K): R and flags are valid, done = 1, busy = 0.
- Latency from start edge to done = M/K cycles. With M = 4, K = 1: 4 cycles. With M = 8, K = 4: 2 cycles.
- done is high for exactly one cycle. Because busy = 0 in that cycle, a start there is accepted (back-to-back operations).
- Throughput: one operation per M/K cycles.

## Test plan
- M=4, K=1, sub: A=5, B=3 → after 4 cycles done pulse, R=2, NZCV=0000; busy high exactly 4 cycles.
- M=4, K=1, sub: A=3, B=5 → R=4'b1110, N=1, Z=0, C=1, V=0. Also A=5, B=5 → R=0, Z=1, C=0.
- M=4, K=1 overflow cases:
  - sub, A=4'b1000, B=1 → R=4'b0111, V=1, N=0, C=0.
  - add, A=7, B=1 → R=4'b1000, V=1, N=1, C=0.
  - add, A=15, B=1 → R=0, C=1, Z=1, V=0.
- M=8, K=4, sub: A=8'h10, B=8'h01 → done 2 cycles after start, R=8'h0F, NZCV=0000.
- Handshake:
  - Pulse start again during busy with new operands → ignored; R reflects the first operation only.
  - Start in the done cycle → accepted; second result arrives M/K cycles later.
- Reset: drop rst_n asynchronously mid-RUN (cycle 2 of 4) → busy, done, R and flags go to 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/resta_serial.sv
// Sequential add/subtract unit: K-bit slice adder reused over M/K cycles,
// start/done handshake, registered result and NZCV flags.
module resta_serial #(
  parameter int unsigned M = 4,
  parameter int unsigned K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] R,
  output logic         N,
  output logic         Z,
  output logic         C,
  output logic         V
);

  generate
    if (M < 2 || K < 1 || K > M || (M % K) != 0) begin : g_param_check
      $error("resta_serial: invalid parameters M=%0d K=%0d", M, K);
    end
  endgenerate

  localparam int unsigned SLICES = M / K;
  localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   a_q, b_q;
  logic [M-1:0]   a_next;
  logic           c_q;
  logic           sa_q, sb_q, mode_q;
  logic [CW-1:0]  cnt_q;
  logic [K:0]     sum;
  logic           last;
  logic [M-1:0]   r_q;
  logic           n_q, z_q, c_flag_q, v_q, done_q;

  assign sum  = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, c_q};
  // a_q doubles as the partial-result register: sums enter from the MSB side
  // as operand bits leave from the LSB side, so after M/K slices it holds R.
  assign a_next = M'({sum[K-1:0], a_q} >> K);
  assign last   = (cnt_q == CW'(SLICES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    R    = r_q;
    N    = n_q;
    Z    = z_q;
    C    = c_flag_q;
    V    = v_q;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_flag_q <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= mode ? B : ~B;
            c_q    <= ~mode;
            sa_q   <= A[M-1];
            sb_q   <= B[M-1];
            mode_q <= mode;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          a_q   <= a_next;
          b_q   <= b_q >> K;
          c_q   <= sum[K];
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            r_q      <= a_next;
            n_q      <= a_next[M-1];
            z_q      <= (a_next == '0);
            c_flag_q <= mode_q ? sum[K] : ~sum[K];
            v_q      <= mode_q ? ((sa_q == sb_q) && (a_next[M-1] != sa_q))
                               : ((sa_q != sb_q) && (a_next[M-1] != sa_q));
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resta_serial.sv
// Directed bench for resta_serial: M=4/K=1 and M=8/K=4 instances,
// hand-computed results, flags, latency, handshake and async reset.
module tb_resta_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0, mode4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, n4, z4, c4, v4;
  logic [3:0] r4;

  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, n8, z8, c8, v8;
  logic [7:0] r8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  resta_serial #(.M(4), .K(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .R(r4), .N(n4), .Z(z4), .C(c4), .V(v4)
  );

  resta_serial #(.M(8), .K(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .R(r8), .N(n8), .Z(z8), .C(c8), .V(v8)
  );

  // Drives one M=4 operation and waits (bounded) for done; reports cycles
  // from start edge to done and the number of busy samples seen.
  task automatic op4(input logic md, input logic [3:0] a, input logic [3:0] b,
                     output int cyc, output int bsy);
    start4 = 1'b1; mode4 = md; a4 = a; b4 = b;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0; bsy = 0;
    while (!done4 && cyc < 20) begin
      if (busy4) bsy++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic op8(input logic md, input logic [7:0] a, input logic [7:0] b,
                     output int cyc);
    start8 = 1'b1; mode8 = md; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({busy4, done4, r4, n4, z4, c4, v4} !== 10'b0) begin
      failures++;
      $display("FAIL reset_u4: got %b expected %b", {busy4, done4, r4, n4, z4, c4, v4}, 10'b0);
    end
    checks++;
    if ({busy8, done8, r8, n8, z8, c8, v8} !== 14'b0) begin
      failures++;
      $display("FAIL reset_u8: got %b expected %b", {busy8, done8, r8, n8, z8, c8, v8}, 14'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sub_basic;
    int cyc, bsy;
    op4(1'b0, 4'd5, 4'd3, cyc, bsy);
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL sub_5_3_latency: got %0d expected 4", cyc); end
    checks++;
    if (bsy !== 4) begin failures++; $display("FAIL sub_5_3_busy_cycles: got %0d expected 4", bsy); end
    checks++;
    if (busy4 !== 1'b0) begin failures++; $display("FAIL sub_5_3_busy_at_done: got %b expected 0", busy4); end
    checks++;
    if (r4 !== 4'd2) begin failures++; $display("FAIL sub_5_3_R: got %h expected 2", r4); end
    checks++;
    if ({n4, z4, c4, v4} !== 4'b0000) begin
      failures++; $display("FAIL sub_5_3_NZCV: got %b expected 0000", {n4, z4, c4, v4});
    end
    @(posedge clk); #1;
    checks++;
    if (done4 !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %b expected 0", done4); end
  endtask

  task automatic test_sub_neg_zero;
    int cyc, bsy;
    op4(1'b0, 4'd3, 4'd5, cyc, bsy);
    checks++;
    if ({r4, n4, z4, c4, v4} !== {4'b1110, 4'b1010}) begin
      failures++; $display("FAIL sub_3_5: got R=%b NZCV=%b expected R=1110 NZCV=1010", r4, {n4, z4, c4, v4});
    end
    op4(1'b0, 4'd5, 4'd5, cyc, bsy);
    checks++;
    if ({r4, n4, z4, c4, v4} !== {4'b0000, 4'b0100}) begin
      failures++; $display("FAIL sub_5_5: got R=%b NZCV=%b expected R=0000 NZCV=0100", r4, {n4, z4, c4, v4});
    end
  endtask

  task automatic test_overflow;
    int cyc, bsy;
    op4(1'b0, 4'b1000, 4'd1, cyc, bsy);
    checks++;
    if ({r4, n4, z4, c4, v4} !== {4'b0111, 4'b0001}) begin
      failures++; $display("FAIL sub_8_1_ovf: got R=%b NZCV=%b expected R=0111 NZCV=0001", r4, {n4, z4, c4, v4});
    end
    op4(1'b1, 4'd7, 4'd1, cyc, bsy);
    checks++;
    if ({r4, n4, z4, c4, v4} !== {4'b1000, 4'b1001}) begin
      failures++; $display("FAIL add_7_1_ovf: got R=%b NZCV=%b expected R=1000 NZCV=1001", r4, {n4, z4, c4, v4});
    end
    op4(1'b1, 4'd15, 4'd1, cyc, bsy);
    checks++;
    if ({r4, n4, z4, c4, v4} !== {4'b0000, 4'b0110}) begin
      failures++; $display("FAIL add_15_1_carry: got R=%b NZCV=%b expected R=0000 NZCV=0110", r4, {n4, z4, c4, v4});
    end
  endtask

  task automatic test_k4;
    int cyc;
    op8(1'b0, 8'h10, 8'h01, cyc);
    checks++;
    if (cyc !== 2) begin failures++; $display("FAIL k4_latency: got %0d expected 2", cyc); end
    checks++;
    if ({r8, n8, z8, c8, v8} !== {8'h0F, 4'b0000}) begin
      failures++; $display("FAIL k4_sub_10_01: got R=%h NZCV=%b expected R=0f NZCV=0000", r8, {n8, z8, c8, v8});
    end
    op8(1'b1, 8'h7F, 8'h01, cyc);
    checks++;
    if ({r8, n8, z8, c8, v8} !== {8'h80, 4'b1001}) begin
      failures++; $display("FAIL k4_add_7f_01: got R=%h NZCV=%b expected R=80 NZCV=1001", r8, {n8, z8, c8, v8});
    end
  endtask

  task automatic test_ignored_start;
    int cyc;
    int extra_done;
    start4 = 1'b1; mode4 = 1'b0; a4 = 4'd5; b4 = 4'd3;
    @(posedge clk); #1;
    start4 = 1'b0; mode4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 2;
    while (!done4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL ignore_latency: got %0d expected 4", cyc); end
    checks++;
    if (r4 !== 4'd2) begin failures++; $display("FAIL ignore_R: got %h expected 2", r4); end
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) extra_done++;
    end
    checks++;
    if (extra_done !== 0 || r4 !== 4'd2) begin
      failures++; $display("FAIL ignore_no_second_op: got activity=%0d R=%h expected 0 and 2", extra_done, r4);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bsy;
    op4(1'b0, 4'd5, 4'd3, cyc, bsy);
    start4 = 1'b1; mode4 = 1'b1; a4 = 4'd7; b4 = 4'd1;
    @(posedge clk); #1;
    start4 = 1'b0;
    checks++;
    if ({busy4, done4} !== 2'b10) begin
      failures++; $display("FAIL b2b_accept: got busy,done=%b expected 10", {busy4, done4});
    end
    cyc = 0;
    while (!done4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL b2b_latency: got %0d expected 4", cyc); end
    checks++;
    if ({r4, n4, z4, c4, v4} !== {4'b1000, 4'b1001}) begin
      failures++; $display("FAIL b2b_result: got R=%b NZCV=%b expected R=1000 NZCV=1001", r4, {n4, z4, c4, v4});
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc, bsy;
    int seen;
    op4(1'b0, 4'd3, 4'd5, cyc, bsy);
    start4 = 1'b1; mode4 = 1'b0; a4 = 4'd5; b4 = 4'd3;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, r4, n4, z4, c4, v4} !== 10'b0) begin
      failures++; $display("FAIL async_reset: got %b expected %b", {busy4, done4, r4, n4, z4, c4, v4}, 10'b0);
    end
    #3;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4 || r4 != 4'd0) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL reset_no_done: got %0d active samples expected 0", seen); end
  endtask

  initial begin
    test_reset;
    test_sub_basic;
    test_sub_neg_zero;
    test_overflow;
    test_k4;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
